// File: rtl/add_result_accum.sv
// Batch accumulator for 4-bit adder results: sums BATCH beats into an
// ACC_W-bit total with a sticky overflow flag, then holds it for a downstream handshake.
module add_result_accum #(
  parameter int ACC_W = 8,
  parameter int BATCH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sum,
  input  logic             in_cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(BATCH + 1);

  if (ACC_W < 4 || ACC_W > 16) begin : g_bad_acc_w
    $error("add_result_accum: ACC_W must be within 4..16");
  end
  if (BATCH < 1 || BATCH > 15) begin : g_bad_batch
    $error("add_result_accum: BATCH must be within 1..15");
  end

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_PRESENT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W:0]     beat_ext;
  logic [ACC_W:0]     sum_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_beat;

  // One extra bit on the adder exposes the carry that feeds the sticky flag.
  assign beat_ext  = {{(ACC_W - 3){1'b0}}, in_cout, in_sum};
  assign sum_ext   = {1'b0, acc_q} + beat_ext;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_beat = (cnt_q == CNT_W'(BATCH - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = S_COLLECT;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            acc_d = sum_ext[ACC_W-1:0];
            ovf_d = ovf_q | sum_ext[ACC_W];
            cnt_d = cnt_inc;
            if (last_beat) begin
              state_d = S_PRESENT;
            end
          end
        end
        S_PRESENT: begin
          // Beats offered here are left for upstream to hold; the handshake
          // edge only restarts the batch.
          if (out_ready) begin
            state_d = S_COLLECT;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_COLLECT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs come straight from registers, so no input reaches them combinationally.
  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_PRESENT);
  assign out_total = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_result_accum.sv
// Drives four parameterisations of add_result_accum from one shared stimulus
// stream and compares every output against a per-instance batch-sum model.
module tb_add_result_accum;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [2:0] in_sum;
  logic in_cout;
  logic clear;
  logic out_ready;

  logic        ir   [N];
  logic        ov   [N];
  logic        ovf  [N];
  logic [15:0] tot  [N];

  logic [7:0]  tot0;
  logic [3:0]  tot1;
  logic [7:0]  tot2;
  logic [15:0] tot3;

  int total = 0;
  int bad   = 0;

  // Reference state: plain integer sum of the batch so far, beats counted,
  // and whether a completed batch is waiting for the downstream.
  int msum [N];
  int mcnt [N];
  bit mpres[N];

  always #5 clk = ~clk;

  add_result_accum #(.ACC_W(8),  .BATCH(4))  d0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(ov[0]), .out_ready(out_ready), .out_total(tot0), .out_ovf(ovf[0]));
  add_result_accum #(.ACC_W(4),  .BATCH(4))  d1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(ov[1]), .out_ready(out_ready), .out_total(tot1), .out_ovf(ovf[1]));
  add_result_accum #(.ACC_W(8),  .BATCH(1))  d2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(ov[2]), .out_ready(out_ready), .out_total(tot2), .out_ovf(ovf[2]));
  add_result_accum #(.ACC_W(16), .BATCH(15)) d3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(ov[3]), .out_ready(out_ready), .out_total(tot3), .out_ovf(ovf[3]));

  assign tot[0] = {8'h00, tot0};
  assign tot[1] = {12'h000, tot1};
  assign tot[2] = {8'h00, tot2};
  assign tot[3] = tot3;

  function automatic int width_of(input int i);
    case (i)
      1:       return 4;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int batch_of(input int i);
    case (i)
      2:       return 1;
      3:       return 15;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      msum[i]  = 0;
      mcnt[i]  = 0;
      mpres[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int m;
      m = 1 << width_of(i);
      check("in_ready",  i, {15'd0, ir[i]},  {15'd0, ~mpres[i]});
      check("out_valid", i, {15'd0, ov[i]},  {15'd0, mpres[i]});
      check("out_total", i, tot[i],           16'(msum[i] % m));
      check("out_ovf",   i, {15'd0, ovf[i]}, {15'd0, (msum[i] >= m)});
    end
  endtask

  // One clock: the model applies the protocol rules to the inputs held
  // across the edge, then outputs are compared 1 ns after the edge.
  task automatic tick();
    int v;
    @(posedge clk);
    v = {in_cout, in_sum};
    for (int i = 0; i < N; i++) begin
      if (!rst_n || clear) begin
        msum[i] = 0; mcnt[i] = 0; mpres[i] = 1'b0;
      end else if (mpres[i]) begin
        if (out_ready) begin
          msum[i] = 0; mcnt[i] = 0; mpres[i] = 1'b0;
        end
      end else if (in_valid) begin
        msum[i] += v;
        mcnt[i]++;
        if (mcnt[i] == batch_of(i)) mpres[i] = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic beat(input int v);
    in_valid = 1'b1;
    {in_cout, in_sum} = 4'(v);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_sum = 3'd0; in_cout = 1'b0; clear = 1'b0; out_ready = 1'b1;
    // Reset takes effect with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_zero();
    check_all();
    check("rst_total", 0, tot[0], 16'h0000);
    @(posedge clk); #1;
    check_all();

    // Release with a beat already offered: the first edge accepts it.
    in_valid = 1'b1; {in_cout, in_sum} = 4'd5;
    rst_n = 1'b1;
    tick();
    beat(7); beat(14); beat(1);
    check("total_27", 0, tot[0], 16'd27);
    check("ovf_27",   0, {15'd0, ovf[0]}, 16'd0);
    check("valid_27", 0, {15'd0, ov[0]}, 16'd1);
    // Handshake cycle with a beat offered: not consumed.
    beat(9);
    check("ready_after", 0, {15'd0, ir[0]}, 16'd1);
    check("total_clr",   0, tot[0], 16'd0);

    // Backpressure while a total is held.
    do_clear();
    out_ready = 1'b0;
    beat(5); beat(7); beat(14); beat(1);
    beat(9); beat(9); beat(9);
    check("hold_total", 0, tot[0], 16'd27);
    check("hold_ready", 0, {15'd0, ir[0]}, 16'd0);
    out_ready = 1'b1;
    beat(9);
    beat(9);
    check("first_after", 0, tot[0], 16'd9);

    // 4-bit accumulator wraps and flags overflow.
    do_clear();
    beat(14); beat(14); beat(1); beat(0);
    check("w4_total", 1, tot[1], 16'd13);
    check("w4_ovf",   1, {15'd0, ovf[1]}, 16'd1);
    idle(1);
    beat(1); beat(1); beat(1); beat(1);
    check("w4_total2", 1, tot[1], 16'd4);
    check("w4_ovf2",   1, {15'd0, ovf[1]}, 16'd0);
    idle(1);

    // Clear beats a simultaneous accepted beat.
    do_clear();
    beat(3); beat(3);
    clear = 1'b1;
    beat(8);
    clear = 1'b0;
    beat(1); beat(1); beat(1); beat(1);
    check("clr_total", 0, tot[0], 16'd4);
    idle(1);

    // Asynchronous reset mid-batch discards the partial sum.
    do_clear();
    beat(15); beat(15);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_zero();
    check_all();
    check("rst_mid", 0, tot[0], 16'd0);
    #2 rst_n = 1'b1;
    beat(2); beat(2); beat(2); beat(2);
    check("rst_total8", 0, tot[0], 16'd8);
    check("rst_ovf8",   0, {15'd0, ovf[0]}, 16'd0);
    idle(1);

    // Random traffic: valid, backpressure, occasional clear.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      {in_cout, in_sum} = 4'($urandom_range(0, 15));
      tick();
    end
    clear = 1'b0;
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
